// File: rtl/muldiv_if.sv
// Operand/result bundle between the ID/EX register and the M-extension unit.
// The slave modport is the unit side; master is the pipeline side.
interface muldiv_if;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        done;
  logic        stall;

  modport master (
    output start, kill, op, rs1_v, rs2_v, rd,
    input  result, rd_out, done, stall
  );

  modport slave (
    input  start, kill, op, rs1_v, rs2_v, rd,
    output result, rd_out, done, stall
  );
endinterface

// File: rtl/muldiv_ex.sv
// Iterative RV32M unit: 32 radix-2 steps on magnitudes plus one sign fix-up cycle.
// Define MULDIV_DIV_EN to build the restoring divider (DIV/DIVU/REM/REMU).
module muldiv_ex (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        sgn_a;
  logic        sgn_b;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplr;
  logic [63:0] acc_nx;
  logic [63:0] prod;
  logic [31:0] fix;
  logic        go;
  logic        skip;
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

`ifdef MULDIV_DIV_EN
  logic        dz;
  logic [32:0] trial;
  logic [31:0] quo;
  logic [31:0] rem;
  assign skip = 1'b0;
`else
  assign skip = bus.op[2];
`endif

  assign go = bus.start & ~bus.kill;

  assign a_signed = bus.op[2] ? ~bus.op[0]
                              : (bus.op[1:0] != 2'b11);
  assign b_signed = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
  assign a_neg    = a_signed & bus.rs1_v[31];
  assign b_neg    = b_signed & bus.rs2_v[31];
  assign mag_a    = a_neg ? -bus.rs1_v : bus.rs1_v;
  assign mag_b    = b_neg ? -bus.rs2_v : bus.rs2_v;

  assign bus.done  = (state == DONE);
  assign bus.stall = (state == CALC) ||
                     ((state == IDLE) && go && !skip);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = skip ? DONE : CALC;
      CALC: if (cnt[5]) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.kill) state_nx = IDLE;
  end

  always_comb begin
    acc_nx = acc + (mplr[0] ? mcand : 64'd0);
`ifdef MULDIV_DIV_EN
    // Remainder stays below the divisor, so 33 bits hold the shifted trial.
    trial = acc[63:31] - {1'b0, mcand[31:0]};
    if (op_q[2]) begin
      acc_nx = trial[32] ? {acc[62:0], 1'b0}
                         : {trial[31:0], acc[30:0], 1'b1};
    end
`endif
  end

  always_comb begin
    prod = (sgn_a ^ sgn_b) ? -acc : acc;
    fix  = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
`ifdef MULDIV_DIV_EN
    quo = dz ? 32'hFFFF_FFFF
             : ((sgn_a ^ sgn_b) ? -acc[31:0] : acc[31:0]);
    rem = sgn_a ? -acc[63:32] : acc[63:32];
    if (op_q[2]) fix = op_q[1] ? rem : quo;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      sgn_a      <= 1'b0;
      sgn_b      <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplr       <= '0;
      bus.result <= '0;
      bus.rd_out <= '0;
`ifdef MULDIV_DIV_EN
      dz         <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (go) begin
          op_q  <= bus.op;
          rd_q  <= bus.rd;
          sgn_a <= a_neg;
          sgn_b <= b_neg;
          cnt   <= '0;
`ifdef MULDIV_DIV_EN
          dz    <= (bus.rs2_v == 32'd0);
          if (bus.op[2]) begin
            acc   <= {32'd0, mag_a};
            mcand <= {32'd0, mag_b};
            mplr  <= '0;
          end else begin
            acc   <= '0;
            mcand <= {32'd0, mag_a};
            mplr  <= mag_b;
          end
`else
          if (bus.op[2]) begin
            bus.result <= '0;
            bus.rd_out <= bus.rd;
          end else begin
            acc   <= '0;
            mcand <= {32'd0, mag_a};
            mplr  <= mag_b;
          end
`endif
        end
        CALC: if (!bus.kill) begin
          if (!cnt[5]) begin
            cnt  <= cnt + 6'd1;
            acc  <= acc_nx;
            mplr <= mplr >> 1;
            if (!op_q[2]) mcand <= mcand << 1;
          end else begin
            bus.result <= fix;
            bus.rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
